// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-cycle advance/hold/flush of PC, IF/ID, ID/EX, EX/MEM.
// Zero-latency combinational controls; state, flush counter, halted and stall counter update on clk.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_W        = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, HALT} state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  state_t           eval_st;
  logic [2:0]       fcnt_q, fcnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use_hit;
  logic             pc_en_core;

  assign load_use_hit = ex_memread &
                        ((uses_rs_id & (rs_id == ex_rd)) | (uses_rt_id & (rt_id == ex_rd)));

  // Leaving MEM_WAIT resumes whichever phase the preserved flush counter implies.
  always_comb begin
    eval_st = state_q;
    if (state_q == MEM_WAIT) begin
      eval_st = (fcnt_q != 3'd0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    halted_d = halted_q;
    if (state_q != HALT) begin
      if (dmem_stall) begin
        state_d = MEM_WAIT;
      end else begin
        if (branch_taken) begin
          fcnt_d  = FLUSH_RELOAD;
          state_d = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
        end else if (eval_st == FLUSH) begin
          fcnt_d  = fcnt_q - 3'd1;
          state_d = (fcnt_q == 3'd1) ? RUN : FLUSH;
        end else begin
          state_d = RUN;
        end
        if (halt_wb) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pc_en_core = 1'b1;
    ifid_en    = 1'b1;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    if (state_q == HALT) begin
      pc_en_core = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (dmem_stall) begin
      pc_en_core = 1'b0;
      ifid_en    = 1'b0;
      ifid_stall = 1'b1;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (eval_st == FLUSH) begin
      pc_en_core = ~imem_stall;
      ifid_flush = 1'b1;
    end else if (load_use_hit) begin
      pc_en_core = 1'b0;
      ifid_en    = 1'b0;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (imem_stall) begin
      pc_en_core = 1'b0;
      ifid_flush = 1'b1;
    end
    pc_en = pc_en_core;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_core && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded bench: two sequencer instances (3-cycle flush/16-bit counter, 1-cycle flush/4-bit counter)
// driven with identical directed and random stimulus against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       memrd;
    logic [2:0] exrd;
    logic       br;
    logic       imem;
    logic       dmem;
    logic       halt;
  } in_t;

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        halted;
    logic [15:0] stall_cnt;
  } obs_t;

  typedef struct {
    int flush_left;
    bit halted;
    int stalls;
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  drv;
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;

  obs_t qa[$];
  obs_t qb[$];
  mstate_t ma, mb;

  logic        pc_en_a, ifid_en_a, ifid_stall_a, ifid_flush_a, idex_en_a, idex_flush_a, exmem_en_a, halted_a;
  logic [15:0] stall_cnt_a;
  logic        pc_en_b, ifid_en_b, ifid_stall_b, ifid_flush_b, idex_en_b, idex_flush_b, exmem_en_b, halted_b;
  logic [3:0]  stall_cnt_b;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .REG_W(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(drv.rst), .rs_id(drv.rs), .rt_id(drv.rt), .uses_rs_id(drv.urs), .uses_rt_id(drv.urt),
    .ex_memread(drv.memrd), .ex_rd(drv.exrd), .branch_taken(drv.br), .imem_stall(drv.imem),
    .dmem_stall(drv.dmem), .halt_wb(drv.halt), .pc_en(pc_en_a), .ifid_en(ifid_en_a),
    .ifid_stall(ifid_stall_a), .ifid_flush(ifid_flush_a), .idex_en(idex_en_a), .idex_flush(idex_flush_a),
    .exmem_en(exmem_en_a), .halted(halted_a), .stall_cnt(stall_cnt_a)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .REG_W(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(drv.rst), .rs_id(drv.rs), .rt_id(drv.rt), .uses_rs_id(drv.urs), .uses_rt_id(drv.urt),
    .ex_memread(drv.memrd), .ex_rd(drv.exrd), .branch_taken(drv.br), .imem_stall(drv.imem),
    .dmem_stall(drv.dmem), .halt_wb(drv.halt), .pc_en(pc_en_b), .ifid_en(ifid_en_b),
    .ifid_stall(ifid_stall_b), .ifid_flush(ifid_flush_b), .idex_en(idex_en_b), .idex_flush(idex_flush_b),
    .exmem_en(exmem_en_b), .halted(halted_b), .stall_cnt(stall_cnt_b)
  );

  // Reference: what a 5-stage sequencer must do this cycle, then what it remembers after the edge.
  task automatic model(input in_t v, input int fc, input int cw, inout mstate_t m, output obs_t o);
    bit hit;
    o = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_stall: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1,
          idex_flush: 1'b0, exmem_en: 1'b1, halted: m.halted, stall_cnt: 16'(m.stalls)};
    if (v.rst) begin
      m = '{flush_left: 0, halted: 1'b0, stalls: 0};
      o = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1, idex_en: 1'b1,
            idex_flush: 1'b1, exmem_en: 1'b1, halted: 1'b0, stall_cnt: 16'd0};
      return;
    end
    if (m.halted) begin
      o.pc_en = 1'b0; o.ifid_flush = 1'b1; o.idex_flush = 1'b1;
      return;
    end
    if (v.dmem) begin
      o.pc_en = 1'b0; o.ifid_en = 1'b0; o.ifid_stall = 1'b1; o.idex_en = 1'b0; o.exmem_en = 1'b0;
    end else begin
      hit = v.memrd && ((v.urs && v.rs == v.exrd) || (v.urt && v.rt == v.exrd));
      if (v.br) begin
        o.ifid_flush = 1'b1; o.idex_flush = 1'b1;
        m.flush_left = fc - 1;
      end else if (m.flush_left > 0) begin
        o.ifid_flush = 1'b1; o.pc_en = !v.imem;
        m.flush_left--;
      end else if (hit) begin
        o.pc_en = 1'b0; o.ifid_en = 1'b0; o.ifid_stall = 1'b1; o.idex_flush = 1'b1;
      end else if (v.imem) begin
        o.pc_en = 1'b0; o.ifid_flush = 1'b1;
      end
      if (v.halt) m.halted = 1'b1;
    end
    if (!o.pc_en && m.stalls < (1 << cw) - 1) m.stalls++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc_no, got, exp);
    end
  endtask

  task automatic cyc(input in_t v);
    obs_t ea, eb;
    @(posedge clk);
    #1;
    cyc_no++;
    drv = v;
    model(v, 3, 16, ma, ea);
    model(v, 1, 4, mb, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  function automatic in_t idle();
    return '0;
  endfunction

  initial begin : monitor
    obs_t ea, eb, ga, gb;
    forever begin
      @(negedge clk);
      ga = {pc_en_a, ifid_en_a, ifid_stall_a, ifid_flush_a, idex_en_a, idex_flush_a, exmem_en_a, halted_a, stall_cnt_a};
      gb = {pc_en_b, ifid_en_b, ifid_stall_b, ifid_flush_b, idex_en_b, idex_flush_b, exmem_en_b, halted_b, 16'(stall_cnt_b)};
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("dut_a_outputs", 32'(ga), 32'(ea));
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("dut_b_outputs", 32'(gb), 32'(eb));
      end
    end
  end

  initial begin : stimulus
    in_t v;
    drv = idle();
    drv.rst = 1'b1;
    ma = '{flush_left: 0, halted: 1'b0, stalls: 0};
    mb = ma;

    v = idle(); v.rst = 1'b1;
    cyc(v); cyc(v);
    cyc(idle()); cyc(idle());

    // load-use on rs, then the stall must be gone the following cycle
    v = idle(); v.memrd = 1'b1; v.exrd = 3'd3; v.rs = 3'd3; v.urs = 1'b1;
    cyc(v);
    cyc(idle());
    check("lu_stall_cnt", 32'(stall_cnt_a), 32'd1);
    v.urs = 1'b0; cyc(v);
    v.urs = 1'b1; v.memrd = 1'b0; cyc(v);
    v = idle(); v.memrd = 1'b1; v.exrd = 3'd5; v.rt = 3'd5; v.urt = 1'b1; v.rs = 3'd5;
    cyc(v);
    cyc(idle());

    v = idle(); v.br = 1'b1;
    cyc(v); cyc(idle()); cyc(idle()); cyc(idle());

    v = idle(); v.br = 1'b1; v.dmem = 1'b1;
    repeat (4) cyc(v);
    v.dmem = 1'b0; cyc(v);
    cyc(idle()); cyc(idle()); cyc(idle());

    v = idle(); v.br = 1'b1; v.imem = 1'b1; v.memrd = 1'b1; v.exrd = 3'd2; v.rs = 3'd2; v.urs = 1'b1;
    cyc(v); cyc(idle()); cyc(idle());

    // dmem wait landing in the middle of a flush window
    v = idle(); v.br = 1'b1; cyc(v);
    v = idle(); v.dmem = 1'b1; cyc(v); cyc(v);
    v = idle(); v.imem = 1'b1; cyc(v); cyc(idle()); cyc(idle());

    v = idle(); v.imem = 1'b1;
    repeat (20) cyc(v);

    v = idle(); v.halt = 1'b1; cyc(v);
    for (int i = 0; i < 6; i++) begin
      v = in_t'($urandom);
      v.rst = 1'b0;
      cyc(v);
    end
    check("halt_sticky", 32'(halted_a), 32'd1);
    check("halt_pc_en", 32'(pc_en_a), 32'd0);

    v = idle(); v.rst = 1'b1; cyc(v);
    cyc(idle());
    v = idle(); v.imem = 1'b1; cyc(v);
    v = idle(); v.br = 1'b1; cyc(v);
    cyc(idle());
    v = idle(); v.rst = 1'b1; cyc(v);
    #1;
    check("arst_pc_en", 32'(pc_en_a), 32'd0);
    check("arst_ifid_flush", 32'(ifid_flush_a), 32'd1);
    check("arst_stall_cnt", 32'(stall_cnt_a), 32'd0);
    check("arst_halted", 32'(halted_a), 32'd0);
    cyc(idle());

    for (int i = 0; i < 800; i++) begin
      v = idle();
      v.rst   = ($urandom_range(0, 99) < 3);
      v.rs    = 3'($urandom_range(0, 3));
      v.rt    = 3'($urandom_range(0, 3));
      v.exrd  = 3'($urandom_range(0, 3));
      v.urs   = 1'($urandom);
      v.urt   = 1'($urandom);
      v.memrd = ($urandom_range(0, 99) < 40);
      v.br    = ($urandom_range(0, 99) < 12);
      v.imem  = ($urandom_range(0, 99) < 20);
      v.dmem  = ($urandom_range(0, 99) < 15);
      v.halt  = ($urandom_range(0, 99) < 2);
      cyc(v);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
